// File: rtl/node_reg_fifo.sv
// Registered-handshake FIFO stage: every handshake output comes straight from a flop.
// Optional saturating downstream-stall counter enabled by NODE_REG_FIFO_STALL_CNT_EN.
module node_reg_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       valid_up_in,
  input  logic                       ready_down_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_down_out,
  output logic                       ready_up_out,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef NODE_REG_FIFO_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             up_fire, down_fire;

  always_comb begin
    up_fire   = valid_up_in & ready_q;
    down_fire = valid_q & ready_down_in;
    wr_ptr_d  = wr_ptr_q + AW'(up_fire);
    rd_ptr_d  = rd_ptr_q + AW'(down_fire);
    count_d   = count_q + CW'(up_fire) - CW'(down_fire);
    ready_d   = (count_d < CW'(DEPTH));
    valid_d   = (count_d != '0);
    data_d    = data_q;
    // The incoming word becomes the new head when nothing else remains after this cycle's pop.
    if (count_d != '0) begin
      if (up_fire && ((count_q - CW'(down_fire)) == '0)) begin
        data_d = data_in;
      end else begin
        data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (up_fire) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign data_out       = data_q;
  assign valid_down_out = valid_q;
  assign ready_up_out   = ready_q;
  assign count          = count_q;

`ifdef NODE_REG_FIFO_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (valid_q && !ready_down_in && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
